// File: rtl/time_display_mux_if.sv
// Bundles the time inputs and the multiplexed six-digit display outputs.
// The master drives the time and option inputs; the display mux is the slave.
interface time_display_mux_if;
  logic [4:0] hours_i;
  logic [5:0] mins_i;
  logic [5:0] secs_i;
  logic       blank_lead_i;
  logic       dp_en_i;
  logic [5:0] an_o;
  logic [6:0] seg_o;
  logic       dp_o;

  modport master (
    output hours_i, mins_i, secs_i, blank_lead_i, dp_en_i,
    input  an_o, seg_o, dp_o
  );

  modport slave (
    input  hours_i, mins_i, secs_i, blank_lead_i, dp_en_i,
    output an_o, seg_o, dp_o
  );
endinterface

// File: rtl/time_display_mux.sv
// Scans an HH:MM:SS value onto a six-digit common-anode display, converting
// each frame's snapshot to BCD with a double-dabble FSM.
module time_display_mux #(
  parameter int SCAN_DIV = 100000
) (
  input logic               clk,
  input logic               reset,
  time_display_mux_if.slave disp
);

  localparam int CW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] slotCnt_q, slotCnt_d;
  logic [2:0]    digitIdx_q, digitIdx_d;
  logic          frameStart_q;
  logic          pending_q, pending_d;
  logic [4:0]    hoursSnap_q;
  logic [5:0]    minsSnap_q, secsSnap_q;
  logic [13:0]   hWork_q, hWork_d, mWork_q, mWork_d, sWork_q, sWork_d;
  logic [2:0]    shiftCnt_q, shiftCnt_d;
  logic [23:0]   dispBcd_q, dispBcd_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          slotWrap, frameStart, leadBlank;
  logic [3:0]    curDigit;

  // One double-dabble step on {tens, ones, binary}: add 3 to any BCD nibble >= 5, then shift.
  function automatic logic [13:0] dabbleStep(input logic [13:0] w);
    logic [13:0] t;
    t = w;
    if (t[9:6] >= 4'd5)   t[9:6]   = 4'(t[9:6] + 4'd3);
    if (t[13:10] >= 4'd5) t[13:10] = 4'(t[13:10] + 4'd3);
    return {t[12:0], 1'b0};
  endfunction

  function automatic logic [6:0] segCode(input logic [3:0] d);
    case (d)
      4'd0:    segCode = 7'b1000000;
      4'd1:    segCode = 7'b1111001;
      4'd2:    segCode = 7'b0100100;
      4'd3:    segCode = 7'b0110000;
      4'd4:    segCode = 7'b0011001;
      4'd5:    segCode = 7'b0010010;
      4'd6:    segCode = 7'b0000010;
      4'd7:    segCode = 7'b1111000;
      4'd8:    segCode = 7'b0000000;
      4'd9:    segCode = 7'b0010000;
      default: segCode = 7'b1111111;
    endcase
  endfunction

  assign slotWrap   = (slotCnt_q == CW'(SCAN_DIV - 1));
  assign frameStart = slotWrap && (digitIdx_q == 3'd5);
  assign leadBlank  = disp.blank_lead_i && (digitIdx_q == 3'd5) && (dispBcd_q[23:20] == 4'd0);

  always_comb begin
    case (digitIdx_q)
      3'd0:    curDigit = dispBcd_q[3:0];
      3'd1:    curDigit = dispBcd_q[7:4];
      3'd2:    curDigit = dispBcd_q[11:8];
      3'd3:    curDigit = dispBcd_q[15:12];
      3'd4:    curDigit = dispBcd_q[19:16];
      3'd5:    curDigit = dispBcd_q[23:20];
      default: curDigit = 4'd0;
    endcase
  end

  always_comb begin
    slotCnt_d  = slotCnt_q + 1'b1;
    digitIdx_d = digitIdx_q;
    state_d    = state_q;
    pending_d  = pending_q;
    shiftCnt_d = shiftCnt_q;
    hWork_d    = hWork_q;
    mWork_d    = mWork_q;
    sWork_d    = sWork_q;
    dispBcd_d  = dispBcd_q;

    if (slotWrap) begin
      slotCnt_d  = '0;
      digitIdx_d = (digitIdx_q == 3'd5) ? 3'd0 : digitIdx_q + 3'd1;
    end

    case (state_q)
      IDLE: begin
        if (frameStart_q || pending_q) begin
          state_d   = LOAD;
          pending_d = 1'b0;
        end
      end
      LOAD: begin
        hWork_d    = {8'd0, 1'b0, hoursSnap_q};
        mWork_d    = {8'd0, minsSnap_q};
        sWork_d    = {8'd0, secsSnap_q};
        shiftCnt_d = 3'd0;
        state_d    = SHIFT;
      end
      SHIFT: begin
        hWork_d    = dabbleStep(hWork_q);
        mWork_d    = dabbleStep(mWork_q);
        sWork_d    = dabbleStep(sWork_q);
        shiftCnt_d = shiftCnt_q + 3'd1;
        if (shiftCnt_q == 3'd5) state_d = DONE;
      end
      DONE: begin
        dispBcd_d = {hWork_q[13:6], mWork_q[13:6], sWork_q[13:6]};
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A start that arrives mid-conversion is remembered rather than dropped.
    if (frameStart_q && (state_q != IDLE)) pending_d = 1'b1;

    an_d = ~(6'b000001 << digitIdx_q);
    if ((slotCnt_q == '0) || leadBlank) an_d = 6'b111111;
    seg_d = segCode(curDigit);
    dp_d  = ~(disp.dp_en_i && ((digitIdx_q == 3'd2) || (digitIdx_q == 3'd4)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      slotCnt_q    <= '0;
      digitIdx_q   <= 3'd0;
      frameStart_q <= 1'b0;
      pending_q    <= 1'b1;
      hoursSnap_q  <= 5'd0;
      minsSnap_q   <= 6'd0;
      secsSnap_q   <= 6'd0;
      hWork_q      <= 14'd0;
      mWork_q      <= 14'd0;
      sWork_q      <= 14'd0;
      shiftCnt_q   <= 3'd0;
      dispBcd_q    <= 24'd0;
      an_q         <= 6'b111111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      slotCnt_q    <= slotCnt_d;
      digitIdx_q   <= digitIdx_d;
      frameStart_q <= frameStart;
      pending_q    <= pending_d;
      if (frameStart) begin
        hoursSnap_q <= disp.hours_i;
        minsSnap_q  <= disp.mins_i;
        secsSnap_q  <= disp.secs_i;
      end
      hWork_q      <= hWork_d;
      mWork_q      <= mWork_d;
      sWork_q      <= sWork_d;
      shiftCnt_q   <= shiftCnt_d;
      dispBcd_q    <= dispBcd_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign disp.an_o  = an_q;
  assign disp.seg_o = seg_q;
  assign disp.dp_o  = dp_q;

endmodule

// File: tb/tb_time_display_mux.sv
// Directed bench for time_display_mux with a 16-cycle slot; edgeN counts
// rising edges since the last reset release, outputs reflect the count at edgeN-1.
module tb_time_display_mux;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   edgeN = 0;

  always #5 clk = ~clk;

  time_display_mux_if dispIf ();

  time_display_mux #(.SCAN_DIV(16)) dut (
    .clk   (clk),
    .reset (reset),
    .disp  (dispIf)
  );

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0:       segOf = 7'b1000000;
      1:       segOf = 7'b1111001;
      2:       segOf = 7'b0100100;
      3:       segOf = 7'b0110000;
      4:       segOf = 7'b0011001;
      5:       segOf = 7'b0010010;
      6:       segOf = 7'b0000010;
      7:       segOf = 7'b1111000;
      8:       segOf = 7'b0000000;
      default: segOf = 7'b0010000;
    endcase
  endfunction

  function automatic logic [5:0] anOf(input int k);
    logic [5:0] a;
    a = 6'b111111;
    a[k] = 1'b0;
    return a;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int h, input int m, input int s, input logic bl, input logic dpe);
    dispIf.hours_i      = 5'(h);
    dispIf.mins_i       = 6'(m);
    dispIf.secs_i       = 6'(s);
    dispIf.blank_lead_i = bl;
    dispIf.dp_en_i      = dpe;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
    edgeN++;
  endtask

  task automatic runTo(input int target);
    while (edgeN < target) stepEdge();
  endtask

  initial begin
    int digs[6];
    int oor[6];
    applyStimulus(12, 34, 56, 1'b0, 1'b1);
    #12;
    checkOutput("reset_an", {2'b0, dispIf.an_o}, 8'h3F);
    checkOutput("reset_seg", {1'b0, dispIf.seg_o}, 8'h7F);
    checkOutput("reset_dp", {7'b0, dispIf.dp_o}, 8'h01);
    @(negedge clk);
    reset = 1'b1;
    edgeN = 0;

    // Frame 2 is fully converted from 12:34:56.
    $display("[TB] basic frame 12:34:56");
    digs = '{6, 5, 4, 3, 2, 1};
    for (int k = 0; k < 6; k++) begin
      runTo(193 + 16 * k);
      checkOutput($sformatf("blank_cnt0_slot%0d", k), {2'b0, dispIf.an_o}, 8'h3F);
      stepEdge();
      checkOutput($sformatf("an_slot%0d", k), {2'b0, dispIf.an_o}, {2'b0, anOf(k)});
      checkOutput($sformatf("seg_slot%0d", k), {1'b0, dispIf.seg_o}, {1'b0, segOf(digs[k])});
      checkOutput($sformatf("dp_slot%0d", k), {7'b0, dispIf.dp_o}, (k == 2 || k == 4) ? 8'h00 : 8'h01);
      runTo(208 + 16 * k);
      checkOutput($sformatf("an_cnt15_slot%0d", k), {2'b0, dispIf.an_o}, {2'b0, anOf(k)});
    end

    $display("[TB] leading blank");
    runTo(274);
    applyStimulus(5, 34, 56, 1'b1, 1'b1);
    runTo(450);
    checkOutput("hours_ones_5", {1'b0, dispIf.seg_o}, {1'b0, segOf(5)});
    for (int c = 0; c < 16; c++) begin
      runTo(465 + c);
      checkOutput($sformatf("lead_blank_cnt%0d", c), {2'b0, dispIf.an_o}, 8'h3F);
    end
    dispIf.blank_lead_i = 1'b0;
    runTo(562);
    checkOutput("lead_shown_an", {2'b0, dispIf.an_o}, 8'h1F);
    checkOutput("lead_shown_seg", {1'b0, dispIf.seg_o}, {1'b0, segOf(0)});

    $display("[TB] out of range values");
    runTo(576);
    applyStimulus(31, 63, 60, 1'b0, 1'b1);
    oor = '{0, 6, 3, 6, 1, 3};
    for (int k = 0; k < 6; k++) begin
      runTo(770 + 16 * k);
      checkOutput($sformatf("oor_seg_slot%0d", k), {1'b0, dispIf.seg_o}, {1'b0, segOf(oor[k])});
    end

    $display("[TB] mid-frame input change");
    runTo(864);
    applyStimulus(12, 34, 12, 1'b0, 1'b0);
    runTo(994);
    checkOutput("dp_off_slot2", {7'b0, dispIf.dp_o}, 8'h01);
    checkOutput("mins_ones_4", {1'b0, dispIf.seg_o}, {1'b0, segOf(4)});
    runTo(1000);
    dispIf.secs_i = 6'd13;
    runTo(1058);
    checkOutput("tear_old_early", {1'b0, dispIf.seg_o}, {1'b0, segOf(2)});
    runTo(1065);
    checkOutput("tear_old_last", {1'b0, dispIf.seg_o}, {1'b0, segOf(2)});
    stepEdge();
    checkOutput("tear_new_first", {1'b0, dispIf.seg_o}, {1'b0, segOf(3)});
    runTo(1074);
    checkOutput("tear_tens_slot1", {1'b0, dispIf.seg_o}, {1'b0, segOf(1)});

    $display("[TB] reset during conversion");
    runTo(1156);
    reset = 1'b0;
    #1;
    checkOutput("abort_an", {2'b0, dispIf.an_o}, 8'h3F);
    checkOutput("abort_seg", {1'b0, dispIf.seg_o}, 8'h7F);
    checkOutput("abort_dp", {7'b0, dispIf.dp_o}, 8'h01);
    @(negedge clk);
    reset = 1'b1;
    edgeN = 0;
    runTo(1);
    checkOutput("post_reset_blank", {2'b0, dispIf.an_o}, 8'h3F);
    stepEdge();
    checkOutput("post_reset_an", {2'b0, dispIf.an_o}, 8'h3E);
    checkOutput("post_reset_zero", {1'b0, dispIf.seg_o}, {1'b0, segOf(0)});
    runTo(105);
    checkOutput("post_reset_before", {1'b0, dispIf.seg_o}, {1'b0, segOf(0)});
    stepEdge();
    checkOutput("post_reset_after", {1'b0, dispIf.seg_o}, {1'b0, segOf(3)});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/time_display_mux.md
TIME_DISPLAY_MUX -- requirements
Module: time_display_mux

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clk cycles per digit slot; legal range 16..2^20.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 hours  input  5  binary hours from the time counter, 0..31.
REQ-005 mins  input  6  binary minutes, 0..63.
REQ-006 secs  input  6  binary seconds, 0..63.
REQ-007 blank_lead  input  1  1 = suppress hours-tens digit when it is 0.
REQ-008 dp_en  input  1  1 = light separator dots.
REQ-009 an  output  6  digit enables, active-low, an[0] = rightmost digit.
REQ-010 seg  output  7  segments, active-low, seg[6:0] = g,f,e,d,c,b,a.
REQ-011 dp  output  1  decimal point, active-low.

Function
REQ-012 Slot counter SHALL count 0..SCAN_DIV-1 and wrap; at wrap, digit index SHALL advance 0,1,2,3,4,5,0.
REQ-013 Digit map SHALL be: 0 secs ones, 1 secs tens, 2 mins ones, 3 mins tens, 4 hours ones, 5 hours tens.
REQ-014 Frame start SHALL be the cycle in which the digit index wraps 5->0; on that cycle hours/mins/secs SHALL be captured into snapshot registers.
REQ-015 Conversion FSM states: IDLE, LOAD, SHIFT, DONE; IDLE->LOAD on frame start or pending-start flag; LOAD->SHIFT; SHIFT runs exactly 6 cycles (shift-add-3 double-dabble, all three values in parallel); SHIFT->DONE; DONE->IDLE.
REQ-016 In DONE, all six BCD display digits SHALL update in the same cycle (no partial/torn update); between updates they SHALL hold.
REQ-017 Conversion latency: BCD registers valid 9 cycles after the frame-start edge; inputs changing after capture SHALL not affect the current frame.
REQ-018 Values out of range SHALL be shown arithmetically: e.g. secs=60 -> "60", mins=63 -> "63", hours=31 -> "31".
REQ-019 Blanking: for slot count 0 of every slot, an SHALL be 6'b111111 (anti-ghosting); for counts 1..SCAN_DIV-1, exactly the current digit's an bit SHALL be 0.
REQ-020 seg SHALL encode the current digit's BCD value: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000 (bit6..bit0).
REQ-021 If blank_lead=1 and hours tens=0, an[5] SHALL remain 1 for the whole slot 5.
REQ-022 dp SHALL be 0 during digits 2 and 4 when dp_en=1, otherwise 1.
REQ-023 seg, an, dp SHALL be registered outputs (one cycle after the index/count producing them).
REQ-024 A frame start arriving while the FSM is not IDLE SHALL set a pending-start flag, serviced on return to IDLE (unreachable for SCAN_DIV>=16, still required).

Reset
REQ-025 On reset low: slot counter 0, digit index 0, FSM IDLE, snapshots and BCD registers 0, an=111111, seg=1111111, dp=1.
REQ-026 Pending-start flag SHALL be set by reset so the first conversion begins on the first clock after release.
REQ-027 Reset asserted mid-conversion SHALL abort immediately with no BCD update.

Verification
REQ-028 SCAN_DIV=16, hours=12, mins=34, secs=56, dp_en=1 -> after one frame, slots 0..5 show seg 6,5,4,3,2,1; dp=0 only in slots 2 and 4.
REQ-029 Each slot, count 0 -> an=111111; counts 1..15 -> single active-low an bit matching index.
REQ-030 hours=5, blank_lead=1 -> slot 5 an=111111 throughout; blank_lead=0 -> slot 5 shows "0" (1000000).
REQ-031 secs=60, mins=63, hours=31 -> digits read 3,1,6,3,6,0 (slot 5..0).
REQ-032 Change secs 12->13 mid-frame -> displayed 12 until 9 cycles after next frame start, then 13 with all digits switching same cycle.
REQ-033 Assert reset during SHIFT -> outputs go to reset values asynchronously; after release conversion restarts next cycle and completes 9 cycles later.
